name_streamer: RTL and testbench
================================

Name: name_streamer

Overview:
Transmit-side counterpart of the name detector. On a start request it emits the ASCII byte sequence "GAYATRI" one byte per accepted transfer, repeated a programmable number of times. Output uses a valid/ready byte handshake so it can drive the detector's byte input directly or through buffering. Used as a stimulus source and loopback generator for the detector datapath.

Parameters:
CNT_W, 8, width of repetition count and completed-repetition counter
GAP_LEN, 3, number of filler bytes between repetitions (used only when NAME_GAP_EN is defined; must be >= 1)
FILLER, 8'h2E, filler byte value ('.'); must not equal ASCII 'G'

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
start  in  1  start request; sampled only in IDLE
reps  in  CNT_W  number of name repetitions; sampled with start
abort  in  1  synchronous abort; any state returns to IDLE
out_data  out  8  byte being offered
out_valid  out  1  out_data is valid
out_ready  in  1  downstream accepts byte when high with out_valid
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on normal completion
sent_cnt  out  CNT_W  completed repetitions in current or last run

Behaviour:
- Reset values: state IDLE, out_data 8'h00, out_valid 0, busy 0, done 0, sent_cnt 0, character index 0, remaining-reps counter 0.
- Transfer occurs on a clock edge where out_valid && out_ready.
- States: IDLE, SEND, GAP (NAME_GAP_EN only), FIN.
- IDLE: start=1 and reps!=0 -> SEND, index=0, remaining=reps, sent_cnt=0. out_valid=1 with 'G' (8'h47) in the next cycle, so latency is 1 cycle.
- IDLE: start=1 and reps==0 -> FIN, sent_cnt=0, no bytes emitted.
- SEND: out_data = name ROM[index] ('G','A','Y','A','T','R','I' = 47,41,59,41,54,52,49 hex).
  - On transfer with index<6: index+1.
  - On transfer with index==6: sent_cnt+1, remaining-1, index=0.
    - If remaining was 1 -> FIN.
    - Otherwise -> GAP (feature on) or stay in SEND (feature off). With the feature off, repetitions are back-to-back ("...RIGAY...").
- GAP: out_data=FILLER, out_valid=1. Counts GAP_LEN transfers, then -> SEND at index 0.
- FIN: out_valid=0, done=1 for exactly one cycle, then -> IDLE.
- Backpressure: while out_valid && !out_ready, out_data, index and state hold unchanged. out_valid never drops without a transfer, except on abort.
- out_valid is registered and depends only on state. No combinational path from out_ready to out_valid.
- start while busy: ignored, with no effect on reps or the sequence.
- abort (priority over start and transfer): next cycle is IDLE, out_valid=0, no done pulse. sent_cnt holds the count of completed repetitions. A partial name is abandoned.
- start and abort in the same IDLE cycle: abort wins and the block stays IDLE.
- rst mid-operation: immediate return to reset values. Downstream sees the stream truncated.
- sent_cnt saturates nowhere. reps is at most 2^CNT_W-1, so no wrap within a run.

Optional Feature:
NAME_GAP_EN
- Defined: GAP state inserts GAP_LEN FILLER bytes between consecutive repetitions. No filler before the first repetition or after the last.
- Undefined: GAP state and gap counter are not compiled. SEND loops directly to index 0.

Decomposition:
- Shared package name_pkg holds:
  - ASCII constants G, A, Y, T, R, I
  - NAME_LEN=7
  - the name array constant (index -> byte)
  - the streamer state enum typedef
- The detector and the streamer both take their character constants from name_pkg.
- One natural sub-module: name_char_rom (3-bit index in, 8-bit byte out, combinational, from package array).

Test Plan:
- reps=1, out_ready=1 always: start -> bytes 47,41,59,41,54,52,49 on 7 consecutive cycles starting 1 cycle after start; done pulse 1 cycle after last transfer; sent_cnt=1.
- reps=2, out_ready toggling 1,0,1,0: same byte order, data stable during every stall cycle, 14 transfers, sent_cnt=2.
- reps=3, feature off, output looped into detector: detector pulses exactly 3 times, 7 cycles apart; done once.
- reps=0: done pulses 1 cycle after start, out_valid never asserts, sent_cnt=0.
- reps=5, abort after 10th transfer: out_valid low next cycle, no done, sent_cnt=1. A new start with reps=1 then produces a clean "GAYATRI".
- NAME_GAP_EN defined, GAP_LEN=3, reps=2: stream G A Y A T R I . . . G A Y A T R I (17 transfers); a start pulse mid-run is ignored.

Source files
------------

// File: rtl/name_pkg.sv
// Shared character constants, name ROM contents and streamer state encoding.
// The GAP state exists only when NAME_GAP_EN is defined.
package name_pkg;

  localparam logic [7:0] CHAR_G = 8'h47;
  localparam logic [7:0] CHAR_A = 8'h41;
  localparam logic [7:0] CHAR_Y = 8'h59;
  localparam logic [7:0] CHAR_T = 8'h54;
  localparam logic [7:0] CHAR_R = 8'h52;
  localparam logic [7:0] CHAR_I = 8'h49;

  localparam int NAME_LEN = 7;
  localparam int IDX_W    = 3;

  localparam logic [7:0] NAME_ROM [NAME_LEN] =
    '{CHAR_G, CHAR_A, CHAR_Y, CHAR_A, CHAR_T, CHAR_R, CHAR_I};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_FIN  = 2'd2
`ifdef NAME_GAP_EN
    , ST_GAP = 2'd3
`endif
  } stream_state_t;

endpackage

// File: rtl/name_streamer_if.sv
// Byte valid/ready handshake between the streamer and its downstream consumer.
interface name_streamer_if;

  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/name_char_rom.sv
// Combinational lookup of one character of the name; out-of-range index reads 8'h00.
module name_char_rom
  import name_pkg::*;
(
  input  logic [IDX_W-1:0] i_idx,
  output logic [7:0]       o_char
);

  // NOTE: default assignment first so no path through always_comb infers a latch.
  always_comb begin
    o_char = 8'h00;
    if (int'(i_idx) < NAME_LEN) o_char = NAME_ROM[i_idx];
  end

endmodule

// File: rtl/name_streamer.sv
// Emits "GAYATRI" reps times over a valid/ready byte stream.
// Define NAME_GAP_EN to insert GAP_LEN FILLER bytes between repetitions.
module name_streamer
  import name_pkg::*;
#(
  parameter int         CNT_W   = 8,
  parameter int         GAP_LEN = 3,
  parameter logic [7:0] FILLER  = 8'h2E
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   reps,
  input  logic               abort,
  name_streamer_if.master    out_if,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   sent_cnt
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NAME_LEN - 1);

  if (GAP_LEN < 1 || FILLER == CHAR_G) begin : g_bad_cfg
    $error("name_streamer: GAP_LEN must be >= 1 and FILLER must differ from 'G'");
  end

  stream_state_t    r_state;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_remaining;
  logic [CNT_W-1:0] r_sent_cnt;
  logic [7:0]       r_out_data;
  logic             r_out_valid;
  logic             r_busy;
  logic             r_done;

  logic             w_xfer;
  logic             w_last_char;
  logic [IDX_W-1:0] w_next_idx;
  logic [7:0]       w_next_char;

`ifdef NAME_GAP_EN
  localparam int GAP_W = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  logic [GAP_W-1:0] r_gap_cnt;
`endif

  assign w_xfer      = r_out_valid && out_if.out_ready;
  assign w_last_char = (r_idx == LAST_IDX);
  assign w_next_idx  = w_last_char ? '0 : r_idx + IDX_W'(1);

  // The ROM looks one character ahead so out_data can stay registered.
  name_char_rom u_rom (
    .i_idx  (w_next_idx),
    .o_char (w_next_char)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_remaining <= '0;
      r_sent_cnt  <= '0;
      r_out_data  <= 8'h00;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef NAME_GAP_EN
      r_gap_cnt   <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_state     <= ST_IDLE;
        r_out_valid <= 1'b0;
        r_busy      <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_idx       <= '0;
              r_remaining <= reps;
              r_sent_cnt  <= '0;
              r_busy      <= 1'b1;
              if (reps != '0) begin
                r_state     <= ST_SEND;
                r_out_valid <= 1'b1;
                r_out_data  <= CHAR_G;
              end else begin
                r_state <= ST_FIN;
                r_done  <= 1'b1;
              end
            end
          end

          ST_SEND: begin
            if (w_xfer) begin
              r_idx <= w_next_idx;
              if (w_last_char) begin
                r_sent_cnt  <= r_sent_cnt + CNT_W'(1);
                r_remaining <= r_remaining - CNT_W'(1);
                if (r_remaining == CNT_W'(1)) begin
                  r_state     <= ST_FIN;
                  r_out_valid <= 1'b0;
                  r_done      <= 1'b1;
                end else begin
`ifdef NAME_GAP_EN
                  r_state    <= ST_GAP;
                  r_gap_cnt  <= '0;
                  r_out_data <= FILLER;
`else
                  r_out_data <= w_next_char;
`endif
                end
              end else begin
                r_out_data <= w_next_char;
              end
            end
          end

`ifdef NAME_GAP_EN
          ST_GAP: begin
            if (w_xfer) begin
              if (r_gap_cnt == GAP_W'(GAP_LEN - 1)) begin
                r_state    <= ST_SEND;
                r_out_data <= CHAR_G;
              end else begin
                r_gap_cnt <= r_gap_cnt + GAP_W'(1);
              end
            end
          end
`endif

          ST_FIN: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end

          default: begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign out_if.out_data  = r_out_data;
  assign out_if.out_valid = r_out_valid;
  assign busy             = r_busy;
  assign done             = r_done;
  assign sent_cnt         = r_sent_cnt;

endmodule

// File: tb/tb_name_streamer.sv
// Directed bench for name_streamer: byte scoreboard, stall stability and a reference name matcher.
// Expectations follow NAME_GAP_EN when it is defined for the build.
module tb_name_streamer;

  localparam int         CNT_W   = 8;
  localparam int         GAP_LEN = 3;
  localparam logic [7:0] FILLER  = 8'h2E;
`ifdef NAME_GAP_EN
  localparam int REP_SPAN = 7 + GAP_LEN;
`else
  localparam int REP_SPAN = 7;
`endif
  localparam logic [55:0] NAME_WORD = 56'h47_41_59_41_54_52_49;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] reps;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] sent_cnt;

  name_streamer_if u_if ();

  name_streamer #(
    .CNT_W   (CNT_W),
    .GAP_LEN (GAP_LEN),
    .FILLER  (FILLER)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .reps     (reps),
    .abort    (abort),
    .out_if   (u_if),
    .busy     (busy),
    .done     (done),
    .sent_cnt (sent_cnt)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb [$];
  logic [7:0] exp_name [7] = '{8'h47, 8'h41, 8'h59, 8'h41, 8'h54, 8'h52, 8'h49};

  int          cyc = 0;
  int          n_xfer, n_done, n_stall, hits;
  int          first_xfer_cyc, last_xfer_cyc, done_cyc;
  int          hit_cyc [$];
  logic [55:0] win;
  logic        prev_stall;
  logic [7:0]  prev_data;
  logic        toggle_ready;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    n_xfer = 0; n_done = 0; n_stall = 0; hits = 0;
    first_xfer_cyc = -1; last_xfer_cyc = -1; done_cyc = -1;
    hit_cyc.delete();
    win = '0;
    prev_stall = 1'b0;
    prev_data = 8'h00;
  endtask

  task automatic push_run(input int n);
    for (int r = 0; r < n; r++) begin
`ifdef NAME_GAP_EN
      if (r > 0) for (int g = 0; g < GAP_LEN; g++) sb.push_back(FILLER);
`endif
      for (int k = 0; k < 7; k++) sb.push_back(exp_name[k]);
    end
  endtask

  // One clock: monitor at negedge, then return 1 time unit after the next posedge.
  task automatic tick();
    logic [7:0] exp_b;
    @(negedge clk);
    cyc++;
    if (prev_stall) begin
      n_stall++;
      check("stall_valid", {31'd0, u_if.out_valid}, 32'd1);
      check("stall_data", {24'd0, u_if.out_data}, {24'd0, prev_data});
    end
    if (u_if.out_valid && u_if.out_ready && !abort) begin
      if (sb.size() == 0) begin
        check("extra_byte", sb.size(), 32'd1);
      end else begin
        exp_b = sb.pop_front();
        check("byte", {24'd0, u_if.out_data}, {24'd0, exp_b});
      end
      if (n_xfer == 0) first_xfer_cyc = cyc;
      n_xfer++;
      last_xfer_cyc = cyc;
      win = {win[47:0], u_if.out_data};
      if (win == NAME_WORD) begin
        hits++;
        hit_cyc.push_back(cyc);
      end
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    prev_stall = u_if.out_valid && !u_if.out_ready && !abort;
    prev_data  = u_if.out_data;
    @(posedge clk);
    #1;
    if (toggle_ready) u_if.out_ready = ~u_if.out_ready;
  endtask

  task automatic run_until_done(input int budget);
    int left = budget;
    while (n_done == 0 && left > 0) begin
      tick();
      left--;
    end
    check("done_seen", n_done, 32'd1);
  endtask

  task automatic start_run(input logic [CNT_W-1:0] n);
    start = 1'b1;
    reps  = n;
    tick();
    start = 1'b0;
    reps  = '0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; reps = '0;
    u_if.out_ready = 1'b1;
    toggle_ready = 1'b0;
    clear_stats();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, u_if.out_valid}, 32'd0);
    check("rst_data", {24'd0, u_if.out_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sent", {24'd0, sent_cnt}, 32'd0);
    rst = 1'b0;
    tick();

    // reps=1, always ready: 1-cycle latency, 7 back-to-back bytes, done one cycle later.
    clear_stats();
    push_run(1);
    start_run(8'd1);
    check("lat_valid", {31'd0, u_if.out_valid}, 32'd1);
    check("lat_data", {24'd0, u_if.out_data}, 32'h47);
    run_until_done(50);
    check("r1_xfers", n_xfer, 32'd7);
    check("r1_span", last_xfer_cyc - first_xfer_cyc, 32'd6);
    check("r1_done_lat", done_cyc - last_xfer_cyc, 32'd1);
    check("r1_sent", {24'd0, sent_cnt}, 32'd1);
    check("r1_done_low", {31'd0, done}, 32'd0);
    check("r1_idle", {31'd0, busy}, 32'd0);
    check("r1_sb_empty", sb.size(), 32'd0);

    // reps=2 with ready toggling: stalls must hold data, all bytes in order.
    clear_stats();
    push_run(2);
    toggle_ready = 1'b1;
    start_run(8'd2);
    run_until_done(200);
    toggle_ready = 1'b0;
    u_if.out_ready = 1'b1;
    check("r2_xfers", n_xfer, 32'd2 * REP_SPAN - 32'(REP_SPAN - 7));
    check("r2_stalls_seen", {31'd0, n_stall > 0}, 32'd1);
    check("r2_sent", {24'd0, sent_cnt}, 32'd2);
    check("r2_hits", hits, 32'd2);
    check("r2_sb_empty", sb.size(), 32'd0);

    // reps=3 into the reference matcher, with an ignored start pulse mid-run.
    clear_stats();
    push_run(3);
    start_run(8'd3);
    while (n_xfer < 4) tick();
    start = 1'b1;
    reps  = 8'd7;
    tick();
    start = 1'b0;
    reps  = '0;
    run_until_done(200);
    check("r3_hits", hits, 32'd3);
    if (hit_cyc.size() == 3) begin
      check("r3_gap01", hit_cyc[1] - hit_cyc[0], REP_SPAN);
      check("r3_gap12", hit_cyc[2] - hit_cyc[1], REP_SPAN);
    end
    check("r3_sent", {24'd0, sent_cnt}, 32'd3);
    check("r3_sb_empty", sb.size(), 32'd0);
    repeat (3) tick();
    check("r3_single_done", n_done, 32'd1);

    // reps=0: done one cycle after start, no bytes.
    clear_stats();
    start_run(8'd0);
    check("r0_done", {31'd0, done}, 32'd1);
    check("r0_busy", {31'd0, busy}, 32'd1);
    check("r0_valid", {31'd0, u_if.out_valid}, 32'd0);
    tick();
    check("r0_done_low", {31'd0, done}, 32'd0);
    repeat (2) tick();
    check("r0_xfers", n_xfer, 32'd0);
    check("r0_sent", {24'd0, sent_cnt}, 32'd0);

    // start and abort together in IDLE: abort wins.
    clear_stats();
    start = 1'b1; abort = 1'b1; reps = 8'd2;
    tick();
    start = 1'b0; abort = 1'b0; reps = '0;
    check("sa_busy", {31'd0, busy}, 32'd0);
    check("sa_valid", {31'd0, u_if.out_valid}, 32'd0);

    // reps=5 aborted after the 10th transfer, then a clean single run.
    clear_stats();
    push_run(5);
    start_run(8'd5);
    while (n_xfer < 10 && cyc < 5000) tick();
    abort = 1'b1;
    u_if.out_ready = 1'b0;
    tick();
    abort = 1'b0;
    u_if.out_ready = 1'b1;
    check("ab_valid", {31'd0, u_if.out_valid}, 32'd0);
    check("ab_busy", {31'd0, busy}, 32'd0);
    check("ab_sent", {24'd0, sent_cnt}, 32'd1);
    repeat (3) tick();
    check("ab_no_done", n_done, 32'd0);
    check("ab_no_more", n_xfer, 32'd10);
    sb.delete();
    clear_stats();
    push_run(1);
    start_run(8'd1);
    run_until_done(50);
    check("ab_rerun_hits", hits, 32'd1);
    check("ab_rerun_sent", {24'd0, sent_cnt}, 32'd1);
    check("ab_rerun_sb", sb.size(), 32'd0);

    // Asynchronous reset mid-run truncates the stream immediately.
    clear_stats();
    push_run(2);
    start_run(8'd2);
    while (n_xfer < 3) tick();
    #2 rst = 1'b1;
    #1;
    check("mr_valid", {31'd0, u_if.out_valid}, 32'd0);
    check("mr_data", {24'd0, u_if.out_data}, 32'd0);
    check("mr_busy", {31'd0, busy}, 32'd0);
    check("mr_sent", {24'd0, sent_cnt}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    clear_stats();
    repeat (2) tick();
    check("mr_quiet", n_xfer, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
